// File: rtl/pool_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_sched_if: instruction, array-control and status bundle for pool_sched.
// Rev 1.0
// ---------------------------------------------------------------------------
interface pool_sched_if #(
    parameter int CNT_W = 16
);
    logic             ins_vld;
    logic             ins_rdy;
    logic             ins_is_maxp;
    logic [CNT_W-1:0] ins_vec_size_minus_1;
    logic [CNT_W-1:0] ins_n_grp_minus_1;
    logic             arr_start_pulse;
    logic             arr_is_maxp;
    logic [CNT_W-1:0] arr_vec_size_minus_1;
    logic             mxm_dout_vld;
    logic             res_vld;
    logic             busy;
    logic             done_pulse;
    logic             err_overrun;
    logic             err_timeout;

    modport master (
        output ins_vld, ins_is_maxp, ins_vec_size_minus_1, ins_n_grp_minus_1,
               mxm_dout_vld, res_vld,
        input  ins_rdy, arr_start_pulse, arr_is_maxp, arr_vec_size_minus_1,
               busy, done_pulse, err_overrun, err_timeout
    );

    modport slave (
        input  ins_vld, ins_is_maxp, ins_vec_size_minus_1, ins_n_grp_minus_1,
               mxm_dout_vld, res_vld,
        output ins_rdy, arr_start_pulse, arr_is_maxp, arr_vec_size_minus_1,
               busy, done_pulse, err_overrun, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/pool_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_sched: pooling instruction scheduler; optional watchdog via POOL_SCHED_WDOG_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module pool_sched #(
    parameter int SEL_N  = 4,
    parameter int CNT_W  = 16,
    parameter int WDOG_W = 12
) (
    input  wire logic   clk,
    input  wire logic   rstn,
    pool_sched_if.slave bus
);
    localparam int              LG       = $clog2(SEL_N);
    localparam int              RES_W    = CNT_W + LG;
    localparam logic [LG-1:0]   LANE_MAX = LG'(SEL_N - 1);

    if (SEL_N < 2 || (SEL_N & (SEL_N - 1)) != 0 || WDOG_W < 2) begin : g_param_check
        $error("pool_sched: SEL_N must be a power of two >= 2 and WDOG_W >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               rst_sync_q;
    logic [LG-1:0]      lane_q, lane_d;
    logic [CNT_W-1:0]   elem_q, elem_d, grp_q, grp_d;
    logic [RES_W-1:0]   res_cnt_q, res_cnt_d;
    logic               res_done_q, res_done_d;
    logic               is_maxp_q, is_maxp_d;
    logic [CNT_W-1:0]   vec_q, vec_d, n_grp_q, n_grp_d;
    logic               err_ovr_q, err_ovr_d;
    logic               ins_rdy_q, busy_q, start_q, done_q;
    logic               accept, in_cnt, in_res, beat, beat_last, res_ok, res_last, overrun;

    // Assertion is immediate; release is taken on the first clock edge after rstn rises.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync_q <= 1'b0;
        else       rst_sync_q <= 1'b1;
    end

    assign accept    = (state_q == ST_IDLE) && bus.ins_vld;
    assign in_cnt    = (state_q == ST_START) || (state_q == ST_RUN);
    assign in_res    = in_cnt || (state_q == ST_DRAIN);
    assign beat      = bus.mxm_dout_vld && in_cnt;
    assign beat_last = beat && (lane_q == LANE_MAX) && (elem_q == vec_q) && (grp_q == n_grp_q);
    assign res_ok    = bus.res_vld && in_res && !res_done_q;
    assign res_last  = res_ok && (res_cnt_q == {n_grp_q, {LG{1'b1}}});
    assign overrun   = (bus.mxm_dout_vld && !in_cnt)
                     || (bus.res_vld && ((state_q == ST_DONE) || (state_q == ST_IDLE)))
                     || (bus.res_vld && in_res && res_done_q);

`ifdef POOL_SCHED_WDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d, wdog_inc;
    logic              err_to_q, err_to_d;
    assign wdog_inc = wdog_q + WDOG_W'(1);
`endif

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        elem_d     = elem_q;
        grp_d      = grp_q;
        res_cnt_d  = res_cnt_q;
        res_done_d = res_done_q;
        is_maxp_d  = is_maxp_q;
        vec_d      = vec_q;
        n_grp_d    = n_grp_q;
        err_ovr_d  = err_ovr_q | overrun;
`ifdef POOL_SCHED_WDOG_EN
        wdog_d     = wdog_q;
        err_to_d   = err_to_q;
`endif

        // Lane wraps into element, element wraps into group.
        if (beat) begin
            if (lane_q == LANE_MAX) begin
                lane_d = '0;
                if (elem_q == vec_q) begin
                    elem_d = '0;
                    grp_d  = grp_q + CNT_W'(1);
                end else begin
                    elem_d = elem_q + CNT_W'(1);
                end
            end else begin
                lane_d = lane_q + LG'(1);
            end
        end

        if (res_ok) begin
            res_cnt_d = res_cnt_q + RES_W'(1);
            if (res_last) res_done_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_START;
                    is_maxp_d  = bus.ins_is_maxp;
                    vec_d      = bus.ins_vec_size_minus_1;
                    n_grp_d    = bus.ins_n_grp_minus_1;
                    lane_d     = '0;
                    elem_d     = '0;
                    grp_d      = '0;
                    res_cnt_d  = '0;
                    res_done_d = 1'b0;
                    err_ovr_d  = 1'b0;
`ifdef POOL_SCHED_WDOG_EN
                    wdog_d     = '0;
                    err_to_d   = 1'b0;
`endif
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (beat_last) state_d = (res_done_q || res_last) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (res_last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

`ifdef POOL_SCHED_WDOG_EN
        if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
            if (bus.mxm_dout_vld || bus.res_vld) begin
                wdog_d = '0;
            end else if (&wdog_inc) begin
                wdog_d   = '0;
                err_to_d = 1'b1;
                state_d  = ST_IDLE;
            end else begin
                wdog_d = wdog_inc;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q    <= ST_IDLE;
            lane_q     <= '0;
            elem_q     <= '0;
            grp_q      <= '0;
            res_cnt_q  <= '0;
            res_done_q <= 1'b0;
            is_maxp_q  <= 1'b0;
            vec_q      <= '0;
            n_grp_q    <= '0;
            err_ovr_q  <= 1'b0;
            ins_rdy_q  <= 1'b1;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            elem_q     <= elem_d;
            grp_q      <= grp_d;
            res_cnt_q  <= res_cnt_d;
            res_done_q <= res_done_d;
            is_maxp_q  <= is_maxp_d;
            vec_q      <= vec_d;
            n_grp_q    <= n_grp_d;
            err_ovr_q  <= err_ovr_d;
            ins_rdy_q  <= (state_d == ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
            start_q    <= (state_d == ST_START);
            done_q     <= (state_d == ST_DONE);
        end
    end

`ifdef POOL_SCHED_WDOG_EN
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            wdog_q   <= '0;
            err_to_q <= 1'b0;
        end else begin
            wdog_q   <= wdog_d;
            err_to_q <= err_to_d;
        end
    end
    assign bus.err_timeout = err_to_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.ins_rdy              = ins_rdy_q;
    assign bus.busy                 = busy_q;
    assign bus.arr_start_pulse      = start_q;
    assign bus.done_pulse           = done_q;
    assign bus.arr_is_maxp          = is_maxp_q;
    assign bus.arr_vec_size_minus_1 = vec_q;
    assign bus.err_overrun          = err_ovr_q;
endmodule
`default_nettype wire

// File: tb/tb_pool_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pool_sched: directed self-checking bench for pool_sched (SEL_N=4).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pool_sched;
    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    pool_sched_if #(.CNT_W(16)) bus ();

    pool_sched #(.SEL_N(4), .CNT_W(16), .WDOG_W(12)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.ins_vld              = 1'b0;
        bus.ins_is_maxp          = 1'b0;
        bus.ins_vec_size_minus_1 = '0;
        bus.ins_n_grp_minus_1    = '0;
        bus.mxm_dout_vld         = 1'b0;
        bus.res_vld              = 1'b0;
    endtask

    task automatic issue(input logic maxp, input logic [15:0] vec, input logic [15:0] grp);
        bus.ins_vld              = 1'b1;
        bus.ins_is_maxp          = maxp;
        bus.ins_vec_size_minus_1 = vec;
        bus.ins_n_grp_minus_1    = grp;
        tick();
        bus.ins_vld = 1'b0;
    endtask

    task automatic drive(input int n, input logic beat, input logic res);
        for (int i = 0; i < n; i++) begin
            bus.mxm_dout_vld = beat;
            bus.res_vld      = res;
            tick();
        end
        bus.mxm_dout_vld = 1'b0;
        bus.res_vld      = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        quiet();
        repeat (3) tick();
        checks++; if (bus.ins_rdy !== 1'b1) begin errors++; $display("FAIL rst_ins_rdy got %0b want 1", bus.ins_rdy); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", bus.busy); end
        checks++; if (bus.arr_start_pulse !== 1'b0) begin errors++; $display("FAIL rst_start got %0b want 0", bus.arr_start_pulse); end
        checks++; if (bus.done_pulse !== 1'b0) begin errors++; $display("FAIL rst_done got %0b want 0", bus.done_pulse); end
        checks++; if (bus.err_overrun !== 1'b0 || bus.err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err got %0b%0b want 00", bus.err_overrun, bus.err_timeout); end
        checks++; if (bus.arr_is_maxp !== 1'b0 || bus.arr_vec_size_minus_1 !== 16'd0) begin errors++; $display("FAIL rst_fields got %0b/%0d want 0/0", bus.arr_is_maxp, bus.arr_vec_size_minus_1); end
        // Request held from release: first edge only synchronises, second edge accepts.
        rstn = 1'b1;
        bus.ins_vld = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rel_edge1_busy got %0b want 0", bus.busy); end
        tick();
        bus.ins_vld = 1'b0;
        checks++; if (bus.arr_start_pulse !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL rel_edge2_accept got start=%0b busy=%0b want 1/1", bus.arr_start_pulse, bus.busy); end
        drive(4, 1'b1, 1'b1);
        checks++; if (bus.done_pulse !== 1'b1) begin errors++; $display("FAIL rel_done got %0b want 1", bus.done_pulse); end
        tick();
    endtask

    task automatic test_maxpool();
        issue(1'b1, 16'd2, 16'd0);
        checks++; if (bus.arr_start_pulse !== 1'b1 || bus.ins_rdy !== 1'b0) begin errors++; $display("FAIL mp_start got start=%0b rdy=%0b want 1/0", bus.arr_start_pulse, bus.ins_rdy); end
        checks++; if (bus.arr_is_maxp !== 1'b1 || bus.arr_vec_size_minus_1 !== 16'd2) begin errors++; $display("FAIL mp_fields got %0b/%0d want 1/2", bus.arr_is_maxp, bus.arr_vec_size_minus_1); end
        bus.mxm_dout_vld = 1'b1;
        tick();
        checks++; if (bus.arr_start_pulse !== 1'b0) begin errors++; $display("FAIL mp_start_width got %0b want 0", bus.arr_start_pulse); end
        drive(11, 1'b1, 1'b0);
        checks++; if (bus.busy !== 1'b1 || bus.done_pulse !== 1'b0) begin errors++; $display("FAIL mp_drain got busy=%0b done=%0b want 1/0", bus.busy, bus.done_pulse); end
        drive(3, 1'b0, 1'b1);
        checks++; if (bus.done_pulse !== 1'b0) begin errors++; $display("FAIL mp_early_done got %0b want 0", bus.done_pulse); end
        drive(1, 1'b0, 1'b1);
        checks++; if (bus.done_pulse !== 1'b1) begin errors++; $display("FAIL mp_done got %0b want 1", bus.done_pulse); end
        tick();
        checks++; if (bus.done_pulse !== 1'b0 || bus.busy !== 1'b0 || bus.ins_rdy !== 1'b1) begin errors++; $display("FAIL mp_idle got done=%0b busy=%0b rdy=%0b want 0/0/1", bus.done_pulse, bus.busy, bus.ins_rdy); end
        checks++; if (bus.arr_is_maxp !== 1'b1 || bus.err_overrun !== 1'b0) begin errors++; $display("FAIL mp_hold got maxp=%0b ovr=%0b want 1/0", bus.arr_is_maxp, bus.err_overrun); end
    endtask

    task automatic test_coincide();
        issue(1'b0, 16'd0, 16'd1);
        drive(7, 1'b1, 1'b1);
        checks++; if (bus.done_pulse !== 1'b0) begin errors++; $display("FAIL co_early_done got %0b want 0", bus.done_pulse); end
        drive(1, 1'b1, 1'b1);
        checks++; if (bus.done_pulse !== 1'b1 || bus.err_overrun !== 1'b0) begin errors++; $display("FAIL co_done got done=%0b ovr=%0b want 1/0", bus.done_pulse, bus.err_overrun); end
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.done_pulse !== 1'b0) begin errors++; $display("FAIL co_idle got busy=%0b done=%0b want 0/0", bus.busy, bus.done_pulse); end
    endtask

    task automatic test_overrun();
        issue(1'b0, 16'd0, 16'd0);
        drive(4, 1'b1, 1'b0);
        checks++; if (bus.err_overrun !== 1'b0) begin errors++; $display("FAIL ov_clean got %0b want 0", bus.err_overrun); end
        drive(1, 1'b1, 1'b0);
        checks++; if (bus.err_overrun !== 1'b1) begin errors++; $display("FAIL ov_beat got %0b want 1", bus.err_overrun); end
        drive(4, 1'b0, 1'b1);
        checks++; if (bus.done_pulse !== 1'b1) begin errors++; $display("FAIL ov_done got %0b want 1", bus.done_pulse); end
        tick();
        checks++; if (bus.err_overrun !== 1'b1) begin errors++; $display("FAIL ov_sticky got %0b want 1", bus.err_overrun); end
        issue(1'b0, 16'd0, 16'd0);
        checks++; if (bus.err_overrun !== 1'b0) begin errors++; $display("FAIL ov_clear got %0b want 0", bus.err_overrun); end
        drive(4, 1'b0, 1'b1);
        checks++; if (bus.err_overrun !== 1'b0) begin errors++; $display("FAIL ov_res4 got %0b want 0", bus.err_overrun); end
        drive(1, 1'b0, 1'b1);
        checks++; if (bus.err_overrun !== 1'b1) begin errors++; $display("FAIL ov_res5 got %0b want 1", bus.err_overrun); end
        drive(4, 1'b1, 1'b0);
        checks++; if (bus.done_pulse !== 1'b1) begin errors++; $display("FAIL ov_res_done got %0b want 1", bus.done_pulse); end
        tick();
    endtask

    task automatic test_reset_midrun();
        issue(1'b1, 16'd2, 16'd0);
        drive(5, 1'b1, 1'b0);
        rstn = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.ins_rdy !== 1'b1) begin errors++; $display("FAIL mr_idle got busy=%0b rdy=%0b want 0/1", bus.busy, bus.ins_rdy); end
        checks++; if (bus.arr_is_maxp !== 1'b0 || bus.arr_vec_size_minus_1 !== 16'd0) begin errors++; $display("FAIL mr_fields got %0b/%0d want 0/0", bus.arr_is_maxp, bus.arr_vec_size_minus_1); end
        tick();
        rstn = 1'b1;
        tick();
        issue(1'b0, 16'd1, 16'd0);
        checks++; if (bus.arr_start_pulse !== 1'b1 || bus.arr_vec_size_minus_1 !== 16'd1) begin errors++; $display("FAIL mr_accept got start=%0b vec=%0d want 1/1", bus.arr_start_pulse, bus.arr_vec_size_minus_1); end
        drive(4, 1'b1, 1'b0);
        drive(3, 1'b1, 1'b1);
        checks++; if (bus.done_pulse !== 1'b0) begin errors++; $display("FAIL mr_early_done got %0b want 0", bus.done_pulse); end
        drive(1, 1'b1, 1'b1);
        checks++; if (bus.done_pulse !== 1'b1 || bus.err_overrun !== 1'b0) begin errors++; $display("FAIL mr_done got done=%0b ovr=%0b want 1/0", bus.done_pulse, bus.err_overrun); end
        tick();
    endtask

    task automatic test_stall();
        issue(1'b0, 16'd0, 16'd0);
        drive(2, 1'b1, 1'b0);
        repeat (20) tick();
        checks++; if (bus.busy !== 1'b1 || bus.done_pulse !== 1'b0 || bus.err_timeout !== 1'b0) begin errors++; $display("FAIL st_hold got busy=%0b done=%0b to=%0b want 1/0/0", bus.busy, bus.done_pulse, bus.err_timeout); end
        drive(2, 1'b1, 1'b1);
        drive(2, 1'b0, 1'b1);
        checks++; if (bus.done_pulse !== 1'b1) begin errors++; $display("FAIL st_done got %0b want 1", bus.done_pulse); end
        tick();
    endtask

    task automatic test_back_to_back();
        int starts;
        bus.ins_vld              = 1'b1;
        bus.ins_is_maxp          = 1'b0;
        bus.ins_vec_size_minus_1 = 16'd0;
        bus.ins_n_grp_minus_1    = 16'd0;
        tick();
        checks++; if (bus.arr_start_pulse !== 1'b1) begin errors++; $display("FAIL bb_first got %0b want 1", bus.arr_start_pulse); end
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mxm_dout_vld = 1'b1;
            bus.res_vld      = 1'b1;
            tick();
            if (bus.arr_start_pulse === 1'b1) starts++;
        end
        bus.mxm_dout_vld = 1'b0;
        bus.res_vld      = 1'b0;
        checks++; if (starts != 0) begin errors++; $display("FAIL bb_extra_accept got %0d want 0", starts); end
        checks++; if (bus.done_pulse !== 1'b1 || bus.ins_rdy !== 1'b0) begin errors++; $display("FAIL bb_done got done=%0b rdy=%0b want 1/0", bus.done_pulse, bus.ins_rdy); end
        tick();
        checks++; if (bus.ins_rdy !== 1'b1 || bus.arr_start_pulse !== 1'b0) begin errors++; $display("FAIL bb_gap got rdy=%0b start=%0b want 1/0", bus.ins_rdy, bus.arr_start_pulse); end
        tick();
        bus.ins_vld = 1'b0;
        checks++; if (bus.arr_start_pulse !== 1'b1) begin errors++; $display("FAIL bb_second got %0b want 1", bus.arr_start_pulse); end
        drive(4, 1'b1, 1'b1);
        checks++; if (bus.done_pulse !== 1'b1) begin errors++; $display("FAIL bb_second_done got %0b want 1", bus.done_pulse); end
        tick();
    endtask

    initial begin
        test_reset();
        test_maxpool();
        test_coincide();
        test_overrun();
        test_reset_midrun();
        test_stall();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
